// File: rtl/ksa_shuffle_engine.sv
// ksa_shuffle_engine
//   RC4 key-scheduling engine. It can first fill the state array with the
//   identity (s[a] = a). It then runs the swap loop over the whole array:
//     for i = 0..DEPTH-1: j += s[i] + key[i mod KEY_BYTES]; swap s[i], s[j]
//   It drives a single-port synchronous RAM whose read data arrives RD_WAIT
//   cycles after the address is presented.
//
// Ports
//   clk        system clock
//   reset      synchronous active-high reset
//   start      begin an operation (sampled only in IDLE)
//   init_en    sampled with start; 1 = fill the array before shuffling
//   key        KEY_BYTES key bytes, byte 0 in the most significant byte
//   mem_q      RAM read data
//   mem_addr   RAM address (registered)
//   mem_d      RAM write data (registered)
//   mem_wren   RAM write enable (registered)
//   busy       high from the cycle after start is accepted until done
//   done       one-cycle completion pulse
//   state_dbg  current FSM state, for observation only
//
// Handshake: start is a request that is honoured only while IDLE. Once it is
// accepted, busy is high until the cycle in which done pulses. start, key and
// init_en are ignored until the FSM is back in IDLE.
module ksa_shuffle_engine #(
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3,
  parameter int RD_WAIT   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   init_en,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic [DATA_W-1:0]      mem_q,
  output logic [DATA_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_d,
  output logic                   mem_wren,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             state_dbg
);

  localparam int DEPTH = 1 << DATA_W;
  localparam int KI_W  = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int CNT_W = $clog2(RD_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    RD_I = 3'd2,
    RD_J = 3'd3,
    WR_I = 3'd4,
    WR_J = 3'd5,
    DONE = 3'd6
  } state_t;

  state_t                   state_q, state_d;
  logic [8*KEY_BYTES-1:0]   key_q, key_d;
  logic [DATA_W-1:0]        i_q, i_d;
  logic [DATA_W-1:0]        j_q, j_d;
  logic [KI_W-1:0]          key_idx_q, key_idx_d;
  logic [DATA_W-1:0]        si_q, si_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]        mem_d_q, mem_d_d;
  logic                     mem_wren_q, mem_wren_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [7:0]               kbyte;
  logic [DATA_W+7:0]        kb_wide;
  logic [DATA_W-1:0]        kb;

  // Select key byte key_idx. The byte is zero-extended and then cut to
  // DATA_W bits. For arithmetic modulo 2**DATA_W this is the same as adding
  // the whole byte.
  always_comb begin
    kbyte = '0;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (key_idx_q == KI_W'(k)) kbyte = key_q[(KEY_BYTES-1-k)*8 +: 8];
    end
    kb_wide = {{DATA_W{1'b0}}, kbyte};
    kb      = kb_wide[DATA_W-1:0];
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    i_d        = i_q;
    j_d        = j_q;
    key_idx_d  = key_idx_q;
    si_d       = si_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    mem_wren_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          key_d      = key;
          i_d        = '0;
          j_d        = '0;
          key_idx_d  = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          mem_addr_d = '0;
          if (init_en) begin
            state_d    = FILL;
            mem_d_d    = '0;
            mem_wren_d = 1'b1;
          end else begin
            state_d = RD_I;
          end
        end
      end
      // mem_addr doubles as the fill counter.
      FILL: begin
        if (mem_addr_q == DATA_W'(DEPTH - 1)) begin
          state_d    = RD_I;
          mem_addr_d = i_q;
        end else begin
          mem_addr_d = mem_addr_q + 1'b1;
          mem_d_d    = mem_addr_q + 1'b1;
          mem_wren_d = 1'b1;
        end
      end
      RD_I: begin
        if (cnt_q == CNT_W'(RD_WAIT)) begin
          cnt_d      = '0;
          si_d       = mem_q;
          j_d        = j_q + mem_q + kb;
          mem_addr_d = j_d;
          state_d    = RD_J;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // s[j] goes straight to the write-data register for the WR_I cycle.
      RD_J: begin
        if (cnt_q == CNT_W'(RD_WAIT)) begin
          cnt_d      = '0;
          mem_addr_d = i_q;
          mem_d_d    = mem_q;
          mem_wren_d = 1'b1;
          state_d    = WR_I;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_I: begin
        mem_addr_d = j_q;
        mem_d_d    = si_q;
        mem_wren_d = 1'b1;
        state_d    = WR_J;
      end
      WR_J: begin
        if (i_q == DATA_W'(DEPTH - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          i_d        = i_q + 1'b1;
          key_idx_d  = (key_idx_q == KI_W'(KEY_BYTES - 1)) ? '0 : key_idx_q + 1'b1;
          mem_addr_d = i_q + 1'b1;
          state_d    = RD_I;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      key_q      <= '0;
      i_q        <= '0;
      j_q        <= '0;
      key_idx_q  <= '0;
      si_q       <= '0;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      mem_d_q    <= '0;
      mem_wren_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      i_q        <= i_d;
      j_q        <= j_d;
      key_idx_q  <= key_idx_d;
      si_q       <= si_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      mem_wren_q <= mem_wren_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_d     = mem_d_q;
  assign mem_wren  = mem_wren_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
